mult_div_unit: RTL and testbench

- Parametrised, multicycle multiply/divide unit with HI/LO result registers.
- Successor to the fixed 32-bit, state-driven multiplier in the multicycle MIPS datapath.
- Adds signed and unsigned MULT and DIV, a start/busy/done handshake that replaces decoding of the control-unit state, divide-by-zero flagging, and direct HI/LO writes (MTHI/MTLO).
- Sits beside the ALU. The control unit pulses start and waits for done, then MFHI/MFLO reads hi/lo through the register-file write mux.

---
 rtl/mult_div_unit.sv | 98 +++++++++
 tb/tb_mult_div_unit.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// mult_div_unit: multicycle signed/unsigned multiply and divide with HI/LO result registers.
// Ports: clk, reset (sync, active-high); start/op/a/b issue an operation (op: 00 MULT,
// 01 MULTU, 10 DIV, 11 DIVU); hi_load/lo_load/wdata write hi/lo directly when idle;
// busy while running, done pulses one cycle with the result, div_zero flags DIV by zero;
// hi = upper product or remainder, lo = lower product or quotient.
module mult_div_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             hi_load,
   input  logic             lo_load,
   input  logic [WIDTH-1:0] wdata,
   output logic             busy,
   output logic             done,
   output logic             div_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);
   localparam int CW = $clog2(WIDTH + 1);
   typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
   state_t state, state_nx;
   logic               is_div, neg_res, neg_rem, dz;
   logic [CW-1:0]      cnt;
   logic [WIDTH-1:0]   mag_b;
   logic [2*WIDTH-1:0] acc;
   logic               sa, sb, accept, b_zero, qbit;
   logic [WIDTH-1:0]   ma, mb, new_rem, quo, rem;
   logic [WIDTH:0]     msum, dsh;
   logic [2*WIDTH-1:0] prod;
   assign sa      = ~op[0] & a[WIDTH-1];
   assign sb      = ~op[0] & b[WIDTH-1];
   assign ma      = sa ? -a : a;
   assign mb      = sb ? -b : b;
   assign b_zero  = b == '0;
   assign accept  = state == IDLE && start;
   assign busy    = state != IDLE;
   // multiply: acc = {partial product, remaining multiplier bits}
   assign msum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, acc[0] ? mag_b : {WIDTH{1'b0}}};
   // divide: acc = {partial remainder, dividend bits / quotient bits}
   assign dsh     = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
   assign qbit    = dsh >= {1'b0, mag_b};
   // the restored remainder is always below the divisor, so WIDTH bits suffice
   assign new_rem = qbit ? dsh[WIDTH-1:0] - mag_b : dsh[WIDTH-1:0];
   assign prod    = neg_res ? -acc : acc;
   assign quo     = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
   assign rem     = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end
   always_comb begin
      state_nx = state;
      if (accept)                             state_nx = (op[1] && b_zero) ? FIX : RUN;
      else if (state == RUN && cnt == CW'(1)) state_nx = FIX;
      else if (state == FIX)                  state_nx = IDLE;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         done     <= 1'b0;
         div_zero <= 1'b0;
         hi       <= '0;
         lo       <= '0;
         is_div   <= 1'b0;
         neg_res  <= 1'b0;
         neg_rem  <= 1'b0;
         dz       <= 1'b0;
         cnt      <= '0;
         mag_b    <= '0;
         acc      <= '0;
      end else begin
         done <= state == FIX;
         if (state == IDLE && hi_load) hi <= wdata;
         if (state == IDLE && lo_load) lo <= wdata;
         if (accept) begin
            is_div   <= op[1];
            neg_res  <= sa ^ sb;
            neg_rem  <= sa;
            dz       <= op[1] && b_zero;
            cnt      <= CW'(WIDTH);
            mag_b    <= mb;
            acc      <= {{WIDTH{1'b0}}, ma};
            div_zero <= 1'b0;
         end else if (state == RUN) begin
            acc <= is_div ? {new_rem, acc[WIDTH-2:0], qbit} : {msum, acc[WIDTH-1:1]};
            cnt <= cnt - CW'(1);
         end else if (state == FIX) begin
            if (dz)          div_zero <= 1'b1;
            else if (is_div) {hi, lo} <= {rem, quo};
            else             {hi, lo} <= prod;
         end
      end
   end
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed scoreboard bench for mult_div_unit (WIDTH=32).
module tb_mult_div_unit;
   logic        clk = 1'b0, reset = 1'b1, start = 1'b0, hi_load = 1'b0, lo_load = 1'b0;
   logic [1:0]  op = 2'b00;
   logic [31:0] a = '0, b = '0, wdata = '0;
   logic        busy, done, div_zero;
   logic [31:0] hi, lo;
   typedef struct packed {
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dz;
   } exp_t;
   exp_t exp_q[$];
   int n_vec = 0, n_err = 0;

   mult_div_unit #(.WIDTH(32)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
      .hi_load(hi_load), .lo_load(lo_load), .wdata(wdata),
      .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   always @(negedge clk) begin
      if (done) begin
         if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_done: got done=1 expected no result pending");
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("result_hi", 64'(hi), 64'(e.hi));
            chk("result_lo", 64'(lo), 64'(e.lo));
            chk("result_dz", 64'(div_zero), 64'(e.dz));
         end
      end
   end

   task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] eh, input logic [31:0] el, input logic ed);
      start = 1'b1;
      op    = o;
      a     = x;
      b     = y;
      exp_q.push_back('{hi: eh, lo: el, dz: ed});
   endtask

   task automatic wait_done(input int lat, input int inject, input logic [31:0] hold_hi);
      int cyc = 0, bc = 0;
      @(negedge clk);
      start = 1'b0;
      while (!done && cyc < 200) begin
         bc += int'(busy);
         if (inject >= 0 && cyc == inject + 1) chk("hi_hold_in_run", 64'(hi), 64'(hold_hi));
         if (cyc == inject) begin
            start   = 1'b1;
            op      = 2'b00;
            a       = 32'd9;
            b       = 32'd9;
            hi_load = 1'b1;
            wdata   = 32'hDEAD;
         end else begin
            start   = 1'b0;
            hi_load = 1'b0;
         end
         @(negedge clk);
         cyc++;
      end
      chk("latency", 64'(cyc), 64'(lat));
      chk("busy_cycles", 64'(bc), 64'(lat));
      chk("busy_at_done", 64'(busy), 64'd0);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      reset = 1'b0;
      chk("reset_busy", 64'(busy), 64'd0);
      chk("reset_done", 64'(done), 64'd0);
      chk("reset_dz", 64'(div_zero), 64'd0);
      chk("reset_hi", 64'(hi), 64'd0);
      chk("reset_lo", 64'(lo), 64'd0);
      // back-to-back operations, each issued in the previous done cycle
      issue(2'b00, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0);
      wait_done(33, -1, '0);
      issue(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0);
      wait_done(33, -1, '0);
      issue(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0);
      wait_done(33, -1, '0);
      issue(2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
      wait_done(33, -1, '0);
      issue(2'b11, 32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003, 1'b0);
      wait_done(33, -1, '0);
      issue(2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0);
      wait_done(33, -1, '0);
      issue(2'b01, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 1'b0);
      wait_done(33, -1, '0);
      issue(2'b11, 32'h00000005, 32'hFFFFFFFF, 32'h00000005, 32'h00000000, 1'b0);
      wait_done(33, -1, '0);
      // direct writes then divide by zero
      lo_load = 1'b1;
      wdata   = 32'h1234;
      @(negedge clk);
      lo_load = 1'b0;
      hi_load = 1'b1;
      wdata   = 32'h5678;
      @(negedge clk);
      hi_load = 1'b0;
      chk("mthi", 64'(hi), 64'h5678);
      chk("mtlo", 64'(lo), 64'h1234);
      issue(2'b10, 32'h00000009, 32'h00000000, 32'h00005678, 32'h00001234, 1'b1);
      wait_done(1, -1, '0);
      @(negedge clk);
      chk("dz_sticky", 64'(div_zero), 64'd1);
      issue(2'b00, 32'h00000003, 32'h00000004, 32'h00000000, 32'h0000000C, 1'b0);
      @(negedge clk);
      start = 1'b0;
      chk("dz_cleared", 64'(div_zero), 64'd0);
      wait_done(32, -1, '0);
      issue(2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0);
      wait_done(33, -1, '0);
      // start and hi_load during RUN are ignored
      issue(2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
      wait_done(33, 3, 32'h00000001);
      // reset mid-operation
      issue(2'b01, 32'h00000005, 32'h00000006, 32'h0, 32'h0, 1'b0);
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      void'(exp_q.pop_back());
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("midrun_reset_busy", 64'(busy), 64'd0);
      chk("midrun_reset_done", 64'(done), 64'd0);
      chk("midrun_reset_hi", 64'(hi), 64'd0);
      chk("midrun_reset_lo", 64'(lo), 64'd0);
      begin
         int dn = 0;
         repeat (40) begin
            @(negedge clk);
            dn += int'(done);
         end
         chk("no_done_after_reset", 64'(dn), 64'd0);
      end
      issue(2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
      wait_done(33, -1, '0);
      @(negedge clk);
      chk("queue_empty", 64'(exp_q.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
